// File: rtl/lcd_temp_writer_if.sv
// rtl/lcd_temp_writer_if.sv - temperature strobe input and HD44780 write bus bundle
interface lcd_temp_writer_if;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        ready;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic [7:0]  lcd_data;

    modport master (
        output bcd, bcd_valid,
        input  ready, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

    modport slave (
        input  bcd, bcd_valid,
        output ready, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
endinterface

// File: rtl/lcd_temp_writer.sv
// rtl/lcd_temp_writer.sv - HD44780 init and BCD temperature frame writer
module lcd_temp_writer #(
    parameter int POWERUP_CYC = 1000000,
    parameter int CMD_CYC     = 2000,
    parameter int CLR_CYC     = 82000,
    parameter int EN_CYC      = 25
) (
    input  logic               clk,
    input  logic               rst,
    lcd_temp_writer_if.slave   bus
);
    typedef enum logic [1:0] {PWRUP, INIT, IDLE, FRAME} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_HOLD, PH_WAIT} phase_t;

    state_t      state_q;
    phase_t      phase_q;
    logic [31:0] cnt_q;
    logic [3:0]  idx_q;
    logic [15:0] val_q;
    logic [15:0] pend_val_q;
    logic        pend_q;
    logic        ready_q;
    logic        rs_q;
    logic        e_q;
    logic [7:0]  data_q;

    logic [31:0] wait_lim_d;
    logic        wait_done_d;
    logic        last_byte_d;
    logic        consume_d;
    logic [15:0] start_val_d;
    logic [3:0]  next_idx_d;

    // Digit to ASCII; anything that is not a decimal digit shows as '-'
    function automatic logic [7:0] digit(input logic [3:0] d);
        return (d > 4'd9) ? 8'h2D : (8'h30 + {4'h0, d});
    endfunction

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Index 0 is the set-DDRAM-address command, 1..8 are the visible characters
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [15:0] v);
        case (idx)
            4'd0:    return 8'h80;
            4'd1:    return (v[15:12] == 4'd0) ? 8'h20 : digit(v[15:12]);
            4'd2:    return digit(v[11:8]);
            4'd3:    return 8'h2E;
            4'd4:    return digit(v[7:4]);
            4'd5:    return digit(v[3:0]);
            4'd6:    return 8'h20;
            4'd7:    return 8'hDF;
            default: return 8'h43;
        endcase
    endfunction

    // Byte-done and pending-consumption decode shared by the sequencer and pending register
    always_comb begin
        wait_lim_d  = (!rs_q && data_q == 8'h01) ? 32'(CLR_CYC - 1) : 32'(CMD_CYC - 1);
        wait_done_d = (state_q == INIT || state_q == FRAME) && phase_q == PH_WAIT
                      && cnt_q == wait_lim_d;
        last_byte_d = (state_q == INIT) ? (idx_q == 4'd3) : (idx_q == 4'd8);
        consume_d   = wait_done_d && last_byte_d && (pend_q || bus.bcd_valid);
        start_val_d = pend_q ? pend_val_q : bus.bcd;
        next_idx_d  = idx_q + 4'd1;
    end

    // Top-level sequencer, byte engine and pending strobe register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PWRUP;
            phase_q    <= PH_SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            val_q      <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            data_q     <= '0;
        end else begin
            case (state_q)
                PWRUP: begin
                    if (cnt_q == 32'(POWERUP_CYC - 1)) begin
                        state_q <= INIT;
                        idx_q   <= '0;
                        rs_q    <= 1'b0;
                        data_q  <= init_byte(4'd0);
                        phase_q <= PH_SETUP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                IDLE: begin
                    if (bus.bcd_valid) begin
                        state_q <= FRAME;
                        ready_q <= 1'b0;
                        val_q   <= bus.bcd;
                        idx_q   <= '0;
                        rs_q    <= 1'b0;
                        data_q  <= 8'h80;
                        phase_q <= PH_SETUP;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_q <= PH_EN;
                            e_q     <= 1'b1;
                            cnt_q   <= '0;
                        end
                        PH_EN: begin
                            if (cnt_q == 32'(EN_CYC - 1)) begin
                                e_q     <= 1'b0;
                                phase_q <= PH_HOLD;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        PH_HOLD: begin
                            phase_q <= PH_WAIT;
                            cnt_q   <= '0;
                        end
                        default: begin
                            if (!wait_done_d) begin
                                cnt_q <= cnt_q + 32'd1;
                            end else if (!last_byte_d) begin
                                idx_q   <= next_idx_d;
                                rs_q    <= (state_q == FRAME);
                                data_q  <= (state_q == INIT) ? init_byte(next_idx_d)
                                                             : frame_byte(next_idx_d, val_q);
                                phase_q <= PH_SETUP;
                                cnt_q   <= '0;
                            end else if (consume_d) begin
                                state_q <= FRAME;
                                val_q   <= start_val_d;
                                idx_q   <= '0;
                                rs_q    <= 1'b0;
                                data_q  <= 8'h80;
                                phase_q <= PH_SETUP;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                                ready_q <= 1'b1;
                                cnt_q   <= '0;
                            end
                        end
                    endcase
                end
            endcase

            // A strobe arriving while its predecessor is consumed becomes the new pending value
            if (consume_d) begin
                pend_q <= pend_q && bus.bcd_valid;
                if (pend_q && bus.bcd_valid) begin
                    pend_val_q <= bus.bcd;
                end
            end else if (state_q != IDLE && bus.bcd_valid) begin
                pend_q     <= 1'b1;
                pend_val_q <= bus.bcd;
            end
        end
    end

    assign bus.ready    = ready_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_e    = e_q;
    assign bus.lcd_data = data_q;
endmodule

// File: tb/tb_lcd_temp_writer.sv
// tb/tb_lcd_temp_writer.sv - self-checking bench for lcd_temp_writer
module tb_lcd_temp_writer;
    localparam int PWR = 100;
    localparam int CMD = 10;
    localparam int CLR = 50;
    localparam int EN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lcd_temp_writer_if bus();

    lcd_temp_writer #(.POWERUP_CYC(PWR), .CMD_CYC(CMD), .CLR_CYC(CLR), .EN_CYC(EN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ascii_digit(input int d);
        if (d < 10) return 8'(48 + d);
        return 8'(45);
    endfunction

    // Visible characters of a frame, first character in the top byte
    function automatic logic [63:0] model_frame(input logic [15:0] v);
        int tens, units, tenths, hund;
        logic [7:0] t;
        tens   = int'(v[15:12]);
        units  = int'(v[11:8]);
        tenths = int'(v[7:4]);
        hund   = int'(v[3:0]);
        t = (tens == 0) ? 8'd32 : ascii_digit(tens);
        return {t, ascii_digit(units), 8'd46, ascii_digit(tenths), ascii_digit(hund),
                8'd32, 8'd223, 8'd67};
    endfunction

    function automatic int wait_after(input logic rs_v, input logic [7:0] b);
        return (!rs_v && b == 8'h01) ? CLR : CMD;
    endfunction

    task automatic push_init(input int first_gap);
        expq.push_back('{1'b0, 8'h38, first_gap});
        expq.push_back('{1'b0, 8'h0C, CMD + 2});
        expq.push_back('{1'b0, 8'h06, CMD + 2});
        expq.push_back('{1'b0, 8'h01, CMD + 2});
    endtask

    task automatic push_frame(input logic [15:0] v, input int first_gap);
        logic [63:0] f;
        f = model_frame(v);
        expq.push_back('{1'b0, 8'h80, first_gap});
        for (int i = 7; i >= 0; i--) expq.push_back('{1'b1, f[i*8 +: 8], CMD + 2});
    endtask

    task automatic strobe(input logic [15:0] v, input bit push, input int gap);
        @(negedge clk);
        bus.bcd       = v;
        bus.bcd_valid = 1'b1;
        if (push) push_frame(v, gap);
        @(negedge clk);
        bus.bcd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.ready) break;
        end
        if (i == 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: ready never rose, %0d bytes outstanding", name, expq.size());
        end else begin
            check({name, "_drained"}, 64'(expq.size()), 64'd0);
        end
    endtask

    // Cycle monitor: byte order/content, enable width, inter-byte gaps, bus stability, ready
    int         ecnt = 0;
    int         ref_edge = 0;
    int         rise_edge = 0;
    logic       prev_e = 1'b0;
    logic       prev_ready = 1'b0;
    logic [8:0] prev_bus = '0;
    logic       last_rs = 1'b0;
    logic [7:0] last_byte = '0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        ecnt++;
        check("rw_low", 64'(bus.lcd_rw), 64'd0);
        if (rst) begin
            ref_edge   = ecnt;
            prev_e     = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.lcd_e || prev_e)
                check("bus_stable", 64'({bus.lcd_rs, bus.lcd_data}), 64'(prev_bus));
            if (bus.lcd_e && !prev_e) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got rs=%b data=%h expected no byte", bus.lcd_rs, bus.lcd_data);
                end else begin
                    e = expq.pop_front();
                    check("byte", 64'({bus.lcd_rs, bus.lcd_data}), 64'({e.rs, e.data}));
                    if (e.gap >= 0) check("gap", 64'(ecnt - ref_edge), 64'(e.gap));
                end
                rise_edge = ecnt;
                last_rs   = bus.lcd_rs;
                last_byte = bus.lcd_data;
            end
            if (!bus.lcd_e && prev_e) begin
                check("en_width", 64'(ecnt - rise_edge), 64'(EN));
                ref_edge = ecnt;
            end
            if (expq.size() != 0) check("ready_busy", 64'(bus.ready), 64'd0);
            if (bus.ready && !prev_ready)
                check("ready_delay", 64'(ecnt - ref_edge), 64'(wait_after(last_rs, last_byte) + 1));
            prev_e     = bus.lcd_e;
            prev_ready = bus.ready;
        end
        prev_bus = {bus.lcd_rs, bus.lcd_data};
    end

    initial begin
        logic [63:0] f;
        bus.bcd       = 16'h0000;
        bus.bcd_valid = 1'b0;

        f = model_frame(16'h2575);
        check("model_2575", f, 64'h32352E3735_20DF43);
        f = model_frame(16'h0500);
        check("model_0500", f, 64'h20352E3030_20DF43);
        f = model_frame(16'hA900);
        check("model_A900_tens", 64'(f[63:56]), 64'h2D);

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_e", 64'(bus.lcd_e), 64'd0);
        check("rst_rs", 64'(bus.lcd_rs), 64'd0);
        check("rst_data", 64'(bus.lcd_data), 64'd0);
        push_init(PWR + 1);
        rst = 1'b0;
        wait_ready("init");

        strobe(16'h2575, 1'b1, -1);
        wait_ready("f2575");
        strobe(16'h0500, 1'b1, -1);
        wait_ready("f0500");
        strobe(16'hA900, 1'b1, -1);
        wait_ready("fA900");

        // Strobes during a frame: last one wins, input changes do not leak into the frame
        strobe(16'h4321, 1'b1, -1);
        repeat (20) @(negedge clk);
        strobe(16'h1100, 1'b0, 0);
        bus.bcd = 16'hFFFF;
        repeat (20) @(negedge clk);
        strobe(16'h2200, 1'b1, CMD + 2);
        bus.bcd = 16'h9999;
        wait_ready("pending");

        // Strobe during power-up: frame follows init directly
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_init(PWR + 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        strobe(16'h3000, 1'b1, CLR + 2);
        wait_ready("pwrup_pend");

        // Reset while lcd_e is high mid-frame; pending value must be discarded
        strobe(16'h1234, 1'b1, -1);
        strobe(16'h5555, 1'b0, 0);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #3;
            if (bus.lcd_e && expq.size() < 6) break;
        end
        check("pre_rst_e", 64'(bus.lcd_e), 64'd1);
        rst = 1'b1;
        #1;
        check("async_e", 64'(bus.lcd_e), 64'd0);
        check("async_ready", 64'(bus.ready), 64'd0);
        check("async_data", 64'({bus.lcd_rs, bus.lcd_data}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        expq.delete();
        push_init(PWR + 1);
        rst = 1'b0;
        wait_ready("reinit");
        repeat (60) @(negedge clk);
        check("idle_quiet", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_temp_writer.md
LCD_TEMP_WRITER -- requirements
Module: lcd_temp_writer

Interface
REQ-001 Parameter POWERUP_CYC, default 1000000, clk cycles to wait after reset before the first init command (20 ms at 50 MHz).
REQ-002 Parameter CMD_CYC, default 2000, clk cycles to wait after every byte except clear display (40 us).
REQ-003 Parameter CLR_CYC, default 82000, clk cycles to wait after the clear display command 0x01 (1.64 ms).
REQ-004 Parameter EN_CYC, default 25, clk cycles that lcd_e is held high per byte (500 ns).
REQ-005 clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 bcd  input  16  packed BCD temperature: [15:12] tens, [11:8] units, [7:4] tenths, [3:0] hundredths.
REQ-008 bcd_valid  input  1  single-cycle strobe qualifying bcd.
REQ-009 ready  output  1  high only in IDLE after init has completed.
REQ-010 lcd_rs  output  1  HD44780 register select: 0 = command, 1 = data.
REQ-011 lcd_rw  output  1  HD44780 read/write; tied 0 (write only).
REQ-012 lcd_e  output  1  HD44780 enable strobe.
REQ-013 lcd_data  output  8  HD44780 8-bit data bus.

Function
REQ-014 The FSM SHALL have states PWRUP, INIT, IDLE, FRAME; all byte transfers use a common byte engine.
REQ-015 Byte engine SHALL present lcd_rs/lcd_data for 1 setup cycle with lcd_e=0, hold lcd_e=1 for EN_CYC cycles, drive lcd_e=0 for 1 hold cycle with rs/data unchanged, then wait CMD_CYC (CLR_CYC after 0x01) cycles before the next byte.
REQ-016 lcd_rs and lcd_data SHALL change only during the setup cycle of a byte, never while lcd_e=1.
REQ-017 PWRUP SHALL count POWERUP_CYC cycles with lcd_e=0, then enter INIT.
REQ-018 INIT SHALL send commands (rs=0) 0x38, 0x0C, 0x06, 0x01 in that order, then enter IDLE.
REQ-019 In IDLE, a cycle with bcd_valid=1 SHALL latch bcd and enter FRAME on the next cycle; ready drops on that same next cycle.
REQ-020 FRAME SHALL send command 0x80 (rs=0), then 8 data bytes (rs=1): tens, units, 0x2E '.', tenths, hundredths, 0x20, 0xDF (degree), 0x43 'C'.
REQ-021 Digit nibble d in 0..9 SHALL map to 0x30+d; nibble >9 SHALL map to 0x2D '-'.
REQ-022 Leading-zero suppression: tens nibble equal to 0 SHALL be sent as 0x20; units is always a digit.
REQ-023 The frame SHALL use only the value latched at FRAME entry; bcd changes during FRAME SHALL not alter bytes sent.
REQ-024 bcd_valid during PWRUP, INIT or FRAME SHALL be stored in a one-deep pending register (value + flag), last strobe wins.
REQ-025 On FRAME completion (after last wait), if pending flag set the block SHALL clear it and start a new FRAME with the pending value without passing through IDLE; otherwise enter IDLE.
REQ-026 On INIT completion with pending flag set, the block SHALL start FRAME directly with the pending value.
REQ-027 bcd_valid in the same cycle a pending value is consumed SHALL become the new pending value (not lost).
REQ-028 lcd_rw SHALL be 0 in every cycle.

Reset
REQ-029 On rst=1, asynchronously: state=PWRUP, all counters 0, pending flag 0, latched value 0x0000, ready=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
REQ-030 rst asserted mid-byte SHALL drop lcd_e to 0 immediately; after release the full PWRUP and INIT sequence SHALL repeat.

Verification (POWERUP_CYC=100, CMD_CYC=10, CLR_CYC=50, EN_CYC=2)
REQ-031 Release rst, no strobes -> lcd_e low 100 cycles; bytes 0x38,0x0C,0x06,0x01 rs=0, each lcd_e high exactly 2 cycles; 50-cycle gap after 0x01; ready=1 afterwards.
REQ-032 In IDLE, bcd=0x2575 strobe -> 0x80, then rs=1 bytes 0x32,0x35,0x2E,0x37,0x35,0x20,0xDF,0x43; ready=1 after final 10-cycle wait.
REQ-033 bcd=0x0500 -> data bytes 0x20,0x35,0x2E,0x30,0x30,0x20,0xDF,0x43; bcd=0xA900 -> first data byte 0x2D.
REQ-034 During a frame, strobe 0x1100 then 0x2200 -> current frame unchanged; next frame shows 0x32,0x32; no frame for 0x1100; ready stays 0 between frames.
REQ-035 Strobe 0x3000 during PWRUP -> after 0x01 and its 50-cycle wait, FRAME for 0x3000 starts with ready never asserting.
REQ-036 Assert rst while lcd_e=1 in a frame -> lcd_e=0 same cycle; after release, 100-cycle wait and full init re-run; pending value discarded.
